// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer state encodings, BCD digit constants and digit helpers
package timer_pkg;

    localparam int BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX   = 4'd9;
    localparam bcd_t SEC_TEN_MAX = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    typedef struct packed {
        bcd_t m_ten;
        bcd_t m_one;
        bcd_t s_ten;
        bcd_t s_one;
        bcd_t c_ten;
        bcd_t c_one;
    } mmsscc_t;

    function automatic bcd_t bcd_dec_digit(bcd_t d, bcd_t max);
        return (d == '0) ? max : d - 1'b1;
    endfunction

    function automatic bcd_t bcd_inc_digit(bcd_t d, bcd_t max);
        return (d == max) ? '0 : d + 1'b1;
    endfunction

endpackage

// File: rtl/timer_countdown_core_if.sv
// rtl/timer_countdown_core_if.sv - button inputs and MM:SS.CC display outputs of the countdown core
interface timer_countdown_core_if;
    import timer_pkg::*;

    logic timer_mode;
    logic btn_start;
    logic btn_clr;
    logic btn_min_inc;
    logic btn_sec_inc;

    bcd_t tm_m_ten;
    bcd_t tm_m_one;
    bcd_t tm_s_ten;
    bcd_t tm_s_one;
    bcd_t tm_c_ten;
    bcd_t tm_c_one;
    logic tm_running;
    logic tm_done;
    logic tm_alarm;

    modport master (
        output timer_mode, btn_start, btn_clr, btn_min_inc, btn_sec_inc,
        input  tm_m_ten, tm_m_one, tm_s_ten, tm_s_one, tm_c_ten, tm_c_one,
        input  tm_running, tm_done, tm_alarm
    );

    modport slave (
        input  timer_mode, btn_start, btn_clr, btn_min_inc, btn_sec_inc,
        output tm_m_ten, tm_m_one, tm_s_ten, tm_s_one, tm_c_ten, tm_c_one,
        output tm_running, tm_done, tm_alarm
    );

endinterface

// File: rtl/timer_countdown_core_bcd_dec_chain.sv
// rtl/timer_countdown_core_bcd_dec_chain.sv - combinational MM:SS.CC minus one centisecond with zero flags
module bcd_dec_chain
    import timer_pkg::*;
(
    input  mmsscc_t val_i,
    output mmsscc_t dec_o,
    output logic    val_zero_o,
    output logic    dec_zero_o
);

    logic c_one_b;
    logic cc_b;
    logic s_one_b;
    logic ss_b;
    logic m_one_b;

    // Each *_b flag means every digit below that point is zero, so the next digit up borrows.
    always_comb begin
        c_one_b = (val_i.c_one == '0);
        cc_b    = c_one_b && (val_i.c_ten == '0);
        s_one_b = cc_b    && (val_i.s_one == '0);
        ss_b    = s_one_b && (val_i.s_ten == '0);
        m_one_b = ss_b    && (val_i.m_one == '0);

        dec_o.c_one = bcd_dec_digit(val_i.c_one, DIGIT_MAX);
        dec_o.c_ten = c_one_b ? bcd_dec_digit(val_i.c_ten, DIGIT_MAX)   : val_i.c_ten;
        dec_o.s_one = cc_b    ? bcd_dec_digit(val_i.s_one, DIGIT_MAX)   : val_i.s_one;
        dec_o.s_ten = s_one_b ? bcd_dec_digit(val_i.s_ten, SEC_TEN_MAX) : val_i.s_ten;
        dec_o.m_one = ss_b    ? bcd_dec_digit(val_i.m_one, DIGIT_MAX)   : val_i.m_one;
        dec_o.m_ten = m_one_b ? bcd_dec_digit(val_i.m_ten, DIGIT_MAX)   : val_i.m_ten;
    end

    assign val_zero_o = (val_i == '0);
    assign dec_zero_o = (dec_o == '0);

endmodule

// File: rtl/timer_countdown_core.sv
// rtl/timer_countdown_core.sv - MM:SS.CC countdown engine; TIMER_ALARM_EN adds the timed expiry alarm
module timer_countdown_core
    import timer_pkg::*;
#(
    parameter int CS_DIV   = 10000,
    parameter int ALARM_CS = 300
) (
    input  logic                   clk,
    input  logic                   rst,
    timer_countdown_core_if.slave  bus
);

    localparam int            PW         = $clog2(CS_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CS_DIV - 1);

    if (CS_DIV < 2 || ALARM_CS < 1) begin : g_bad_params
        $error("timer_countdown_core: CS_DIV must be >= 2 and ALARM_CS >= 1");
    end

    timer_state_e  state_q;
    mmsscc_t       digits_q;
    mmsscc_t       digits_dec;
    mmsscc_t       digits_inc;
    logic [PW-1:0] presc_q;
    logic          running_q;
    logic          done_q;
    logic          tick;
    logic          val_zero;
    logic          dec_zero;
    logic          start_p;
    logic          clr_p;
    logic          min_p;
    logic          sec_p;

    assign start_p = bus.timer_mode & bus.btn_start;
    assign clr_p   = bus.timer_mode & bus.btn_clr;
    assign min_p   = bus.timer_mode & bus.btn_min_inc;
    assign sec_p   = bus.timer_mode & bus.btn_sec_inc;
    assign tick    = (presc_q == PRESC_LAST);

    bcd_dec_chain u_dec (
        .val_i      (digits_q),
        .dec_o      (digits_dec),
        .val_zero_o (val_zero),
        .dec_zero_o (dec_zero)
    );

    // Minute and second fields step independently; seconds never carry into minutes.
    always_comb begin
        digits_inc = digits_q;
        if (min_p) begin
            digits_inc.m_one = bcd_inc_digit(digits_q.m_one, DIGIT_MAX);
            if (digits_q.m_one == DIGIT_MAX) begin
                digits_inc.m_ten = bcd_inc_digit(digits_q.m_ten, DIGIT_MAX);
            end
        end
        if (sec_p) begin
            digits_inc.s_one = bcd_inc_digit(digits_q.s_one, DIGIT_MAX);
            if (digits_q.s_one == DIGIT_MAX) begin
                digits_inc.s_ten = bcd_inc_digit(digits_q.s_ten, SEC_TEN_MAX);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            digits_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_p) begin
                state_q   <= ST_IDLE;
                digits_q  <= '0;
                presc_q   <= '0;
                running_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_p) begin
                            if (!val_zero) begin
                                state_q   <= ST_RUN;
                                presc_q   <= '0;
                                running_q <= 1'b1;
                            end
                        end else begin
                            digits_q <= digits_inc;
                        end
                    end
                    ST_RUN: begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            digits_q <= digits_dec;
                        end
                        // A decrement that lands on zero wins over a same-cycle pause request.
                        if (tick && dec_zero) begin
                            state_q   <= ST_EXPIRED;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (start_p) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start_p) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        if (start_p) begin
                            state_q <= ST_IDLE;
                        end
`ifdef TIMER_ALARM_EN
                        presc_q <= tick ? '0 : presc_q + 1'b1;
`endif
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef TIMER_ALARM_EN
    localparam int            AW         = $clog2(ALARM_CS + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CS - 1);

    logic [AW-1:0] alarm_cnt_q;
    logic          alarm_q;
    logic          expire_now;

    assign expire_now = (state_q == ST_RUN) && tick && dec_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else if (clr_p || (state_q == ST_EXPIRED && start_p)) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else if (expire_now) begin
            alarm_q     <= 1'b1;
            alarm_cnt_q <= '0;
        end else if (alarm_q && state_q == ST_EXPIRED && tick) begin
            if (alarm_cnt_q == ALARM_LAST) begin
                alarm_q     <= 1'b0;
                alarm_cnt_q <= '0;
            end else begin
                alarm_cnt_q <= alarm_cnt_q + 1'b1;
            end
        end
    end

    assign bus.tm_alarm = alarm_q;
`else
    assign bus.tm_alarm = 1'b0;
`endif

    assign bus.tm_m_ten   = digits_q.m_ten;
    assign bus.tm_m_one   = digits_q.m_one;
    assign bus.tm_s_ten   = digits_q.s_ten;
    assign bus.tm_s_one   = digits_q.s_one;
    assign bus.tm_c_ten   = digits_q.c_ten;
    assign bus.tm_c_one   = digits_q.c_one;
    assign bus.tm_running = running_q;
    assign bus.tm_done    = done_q;

endmodule

// File: tb/tb_timer_countdown_core.sv
// tb/tb_timer_countdown_core.sv - randomized scoreboard bench for timer_countdown_core against a centisecond-count model
module tb_timer_countdown_core;
    import timer_pkg::*;

    localparam int CS_DIV   = 4;
    localparam int ALARM_CS = 3;
`ifdef TIMER_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_countdown_core_if bus ();

    timer_countdown_core #(.CS_DIV(CS_DIV), .ALARM_CS(ALARM_CS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int total;
        bit running;
        bit done;
        bit alarm;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_seen   = 0;
    int   alarm_seen  = 0;

    // Reference model: the displayed time is one integer count of centiseconds.
    int m_state, m_total, m_presc, m_alarm_left;
    bit m_done;

    task automatic model_reset();
        m_state = S_IDLE; m_total = 0; m_presc = 0; m_alarm_left = 0; m_done = 1'b0;
    endtask

    task automatic model_step(bit tm, bit st, bit cl, bit mi, bit si);
        bit s, c, tick;
        int mm, ss;
        s = tm && st; c = tm && cl;
        m_done = 1'b0;
        if (c) begin
            m_state = S_IDLE; m_total = 0; m_presc = 0; m_alarm_left = 0;
        end else begin
            case (m_state)
                S_IDLE: begin
                    if (s) begin
                        if (m_total != 0) begin m_state = S_RUN; m_presc = 0; end
                    end else begin
                        mm = m_total / 6000;
                        ss = (m_total / 100) % 60;
                        if (tm && mi) mm = (mm + 1) % 100;
                        if (tm && si) ss = (ss + 1) % 60;
                        m_total = mm * 6000 + ss * 100;
                    end
                end
                S_RUN: begin
                    tick = (m_presc == CS_DIV - 1);
                    m_presc = tick ? 0 : m_presc + 1;
                    if (tick) m_total = m_total - 1;
                    if (tick && m_total == 0) begin
                        m_state = S_EXP; m_done = 1'b1;
                        m_alarm_left = ALARM_EN ? ALARM_CS : 0;
                    end else if (s) begin
                        m_state = S_PAUSE;
                    end
                end
                S_PAUSE: if (s) m_state = S_RUN;
                default: begin
                    if (ALARM_EN) begin
                        tick = (m_presc == CS_DIV - 1);
                        m_presc = tick ? 0 : m_presc + 1;
                        if (tick && m_alarm_left > 0) m_alarm_left = m_alarm_left - 1;
                    end
                    if (s) begin m_state = S_IDLE; m_alarm_left = 0; end
                end
            endcase
        end
    endtask

    function automatic logic [26:0] pack_exp(exp_t e);
        int mm, ss, cc;
        mm = e.total / 6000; ss = (e.total / 100) % 60; cc = e.total % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10),
                e.running, e.done, e.alarm};
    endfunction

    function automatic logic [23:0] dut_digits();
        return {bus.tm_m_ten, bus.tm_m_one, bus.tm_s_ten, bus.tm_s_one, bus.tm_c_ten, bus.tm_c_one};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {dut_digits(), bus.tm_running, bus.tm_done, bus.tm_alarm};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(bit tm, bit st, bit cl, bit mi, bit si);
        @(negedge clk);
        bus.timer_mode = tm; bus.btn_start = st; bus.btn_clr = cl;
        bus.btn_min_inc = mi; bus.btn_sec_inc = si;
        model_step(tm, st, cl, mi, si);
        sb_q.push_back('{total: m_total, running: (m_state == S_RUN), done: m_done, alarm: (m_alarm_left > 0)});
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle_check(string name, logic [23:0] exp_digits);
        @(posedge clk);
        #2;
        check(name, 32'(dut_digits()), 32'(exp_digits));
    endtask

    exp_t        mon_e;
    logic [26:0] mon_act, mon_exp;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            done_seen  += int'(bus.tm_done);
            alarm_seen += int'(bus.tm_alarm);
        end
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_exp = pack_exp(mon_e);
            mon_act = dut_vec();
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL sb_vector @%0t: got %h expected %h", $time, mon_act, mon_exp);
            end
        end
    end

    initial begin
        int len, r, n;
        rst = 1'b1;
        bus.timer_mode = 1'b0; bus.btn_start = 1'b0; bus.btn_clr = 1'b0;
        bus.btn_min_inc = 1'b0; bus.btn_sec_inc = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", 32'(dut_vec()), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Setting digits, timer_mode gating
        step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        settle_check("set_02_03", 24'h020300);

        // Field wraps without carry
        step(1, 0, 1, 0, 0);
        repeat (59) step(1, 0, 0, 0, 1);
        settle_check("sec_59", 24'h005900);
        step(1, 0, 0, 0, 1);
        settle_check("sec_wrap_no_carry", 24'h000000);
        repeat (99) step(1, 0, 0, 1, 0);
        settle_check("min_99", 24'h990000);
        step(1, 0, 0, 1, 0);
        settle_check("min_wrap", 24'h000000);

        // First tick latency and start at zero
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        idle(4);
        settle_check("first_tick", 24'h005999);
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        idle(2);

        // Pause, freeze, resume; clr+start together
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        idle(10);
        step(1, 1, 0, 1, 1);
        idle(20);
        step(1, 1, 0, 0, 0);
        idle(10);
        step(1, 1, 1, 0, 0);
        idle(3);

        // Full expiry: done pulse and alarm width
        step(1, 0, 0, 0, 1);
        @(posedge clk); #2;
        done_seen = 0; alarm_seen = 0;
        step(1, 1, 0, 0, 0);
        idle(420);
        @(posedge clk); #2;
        check("done_pulse_count", 32'(done_seen), 32'd1);
        check("alarm_cycles", 32'(alarm_seen), ALARM_EN ? 32'(ALARM_CS * CS_DIV) : 32'd0);
        step(1, 1, 0, 0, 0);
        idle(2);

        // Asynchronous reset mid-run
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        idle(50);
        @(posedge clk); #3;
        rst = 1'b1;
        #1 check("async_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        @(negedge clk) rst = 1'b0;

        // Random episodes
        for (int ep = 0; ep < 25; ep++) begin
            step(1, 0, 1, 0, 0);
            n = $urandom_range(0, 2);
            repeat (n) step(($urandom % 4) != 0, 0, 0, 0, 1);
            step(1, 1, 0, 0, 0);
            len = $urandom_range(20, 500);
            repeat (len) begin
                r = $urandom % 100;
                step(($urandom % 10) != 0, r < 2, (r == 2) && ($urandom % 4 == 0), r >= 90, r >= 95);
            end
            step(1, 1, 0, 0, 0);
            idle($urandom_range(0, 15));
        end

        idle(3);
        @(posedge clk); #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
